// File: rtl/serial_integrator_pkg.sv
// -----------------------------------------------------------------------------
// serial_integrator_pkg
//   Shared definitions for the serial integrator and the downstream
//   saturation stage:
//     - state_t         : integrator FSM encoding (IDLE / MUL / ACC)
//     - DW/KW/AW/FRAC   : default sample, gain, accumulator and fraction widths
//     - sat_max/sat_min : most positive / most negative value of an N-bit
//                         signed word
//     - ACC_MAX/ACC_MIN : those limits at the default accumulator width
// -----------------------------------------------------------------------------
package serial_integrator_pkg;

  localparam int DW_DEF   = 16;
  localparam int KW_DEF   = 12;
  localparam int AW_DEF   = 22;
  localparam int FRAC_DEF = 10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_ACC  = 2'd2
  } state_t;

  function automatic longint sat_max(input int unsigned width);
    return (longint'(1) <<< (width - 1)) - longint'(1);
  endfunction

  function automatic longint sat_min(input int unsigned width);
    return -(longint'(1) <<< (width - 1));
  endfunction

  localparam logic signed [AW_DEF-1:0] ACC_MAX = AW_DEF'(sat_max(AW_DEF));
  localparam logic signed [AW_DEF-1:0] ACC_MIN = AW_DEF'(sat_min(AW_DEF));

endpackage

// File: rtl/serial_integrator_mult.sv
// -----------------------------------------------------------------------------
// serial_mult
//   KW-cycle bit-serial signed multiplier (shift-add, multiplier LSB first).
//   Bits 0..KW-2 of the multiplier add the shifted multiplicand; the sign bit
//   subtracts it, so the DW+KW-bit product is exact for every operand pair,
//   including both most-negative values.
//
//   Ports:
//     clk      in   clock
//     reset    in   synchronous active-high reset
//     abort    in   drop any operation in flight (wins over start)
//     start    in   latch a_in / b_in and begin a multiply
//     a_in     in   DW-bit signed multiplicand
//     b_in     in   KW-bit signed multiplier
//     done     out  high during the cycle that processes the last bit
//     product  out  DW+KW-bit signed product, final after the done cycle
// -----------------------------------------------------------------------------
module serial_mult #(
  parameter int DW = 16,
  parameter int KW = 12
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    abort,
  input  logic                    start,
  input  logic signed [DW-1:0]    a_in,
  input  logic signed [KW-1:0]    b_in,
  output logic                    done,
  output logic signed [DW+KW-1:0] product
);

  localparam int PW = DW + KW;
  localparam int CW = (KW > 1) ? $clog2(KW) : 1;

  logic                 busy_q,   busy_d;
  logic [CW-1:0]        cnt_q,    cnt_d;
  logic signed [PW-1:0] mcand_q,  mcand_d;
  logic [KW-1:0]        mplier_q, mplier_d;
  logic signed [PW-1:0] prod_q,   prod_d;
  logic                 last_bit;

  assign last_bit = busy_q && (cnt_q == CW'(KW - 1));

  always_comb begin
    busy_d   = busy_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;

    if (abort) begin
      busy_d = 1'b0;
      prod_d = '0;
    end else if (start) begin
      mcand_d  = PW'(a_in);
      mplier_d = b_in;
      prod_d   = '0;
      cnt_d    = '0;
      busy_d   = 1'b1;
    end else if (busy_q) begin
      // The multiplier's sign bit carries weight -2^(KW-1): subtract on it.
      if (mplier_q[0]) begin
        if (last_bit) begin
          prod_d = prod_q - mcand_q;
        end else begin
          prod_d = prod_q + mcand_q;
        end
      end
      mcand_d  = mcand_q <<< 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CW'(1);
      if (last_bit) begin
        busy_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q   <= 1'b0;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
    end else begin
      busy_q   <= busy_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
    end
  end

  assign done    = last_bit;
  assign product = prod_q;

endmodule

// File: rtl/serial_integrator.sv
// -----------------------------------------------------------------------------
// serial_integrator
//   Discrete-time integrator: y[n] = y[n-1] + ((ki * x[n]) >>> FRAC).
//   The product comes from a KW-cycle bit-serial multiplier; the accumulator
//   wraps modulo 2^AW unless SERIAL_INTEGRATOR_CLAMP_EN is defined, in which
//   case the sum saturates to the AW-bit signed range (anti-windup).
//
//   Ports:
//     clk        in   clock, rising edge
//     reset      in   synchronous active-high reset
//     clear      in   synchronous accumulator clear / operation abort
//     ki         in   KW-bit signed gain, taken at acceptance
//     sig_in     in   DW-bit signed sample
//     in_valid   in   sample present
//     in_ready   out  sample can be accepted (IDLE, no clear, no reset)
//     sig_out    out  AW-bit signed accumulator (registered)
//     out_valid  out  one-cycle pulse when sig_out has just been updated
//
//   Latency handshake -> out_valid is KW+1 cycles; one sample per KW+2 cycles.
//
//   state | meaning
//   ------+----------------------------------------------------------
//   IDLE  | waiting for a sample; in_ready high unless clear/reset
//   MUL   | KW cycles of shift-add, one gain bit per cycle
//   ACC   | scale product, add to accumulator, pulse out_valid
// -----------------------------------------------------------------------------
module serial_integrator
  import serial_integrator_pkg::*;
#(
  parameter int DW   = DW_DEF,
  parameter int KW   = KW_DEF,
  parameter int AW   = AW_DEF,
  parameter int FRAC = FRAC_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic signed [KW-1:0] ki,
  input  logic signed [DW-1:0] sig_in,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic signed [AW-1:0] sig_out,
  output logic                 out_valid
);

  localparam int PW = DW + KW;

  state_t               state_q,     state_d;
  logic signed [AW-1:0] sig_out_q,   sig_out_d;
  logic                 out_valid_q, out_valid_d;

  logic                 mult_start;
  logic                 mult_abort;
  logic                 mult_done;
  logic signed [PW-1:0] mult_prod;
  logic signed [AW-1:0] acc_next;

  serial_mult #(
    .DW (DW),
    .KW (KW)
  ) u_mult (
    .clk     (clk),
    .reset   (reset),
    .abort   (mult_abort),
    .start   (mult_start),
    .a_in    (sig_in),
    .b_in    (ki),
    .done    (mult_done),
    .product (mult_prod)
  );

  // Scaled product; >>> on a signed operand rounds toward -infinity.
`ifdef SERIAL_INTEGRATOR_CLAMP_EN
  localparam logic signed [AW:0] SUM_MAX = (AW + 1)'(sat_max(AW));
  localparam logic signed [AW:0] SUM_MIN = (AW + 1)'(sat_min(AW));

  logic signed [AW:0] p_ext;
  logic signed [AW:0] sum;

  assign p_ext = (AW + 1)'(mult_prod >>> FRAC);
  assign sum   = (AW + 1)'(sig_out_q) + p_ext;

  always_comb begin
    if (sum > SUM_MAX) begin
      acc_next = SUM_MAX[AW-1:0];
    end else if (sum < SUM_MIN) begin
      acc_next = SUM_MIN[AW-1:0];
    end else begin
      acc_next = sum[AW-1:0];
    end
  end
`else
  logic signed [AW-1:0] p_ext;

  assign p_ext    = AW'(mult_prod >>> FRAC);
  assign acc_next = sig_out_q + p_ext;
`endif

  always_comb begin
    state_d     = state_q;
    sig_out_d   = sig_out_q;
    out_valid_d = 1'b0;
    mult_start  = 1'b0;
    mult_abort  = 1'b0;
    in_ready    = (state_q == ST_IDLE) && !clear && !reset;

    if (clear) begin
      state_d    = ST_IDLE;
      sig_out_d  = '0;
      mult_abort = 1'b1;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (in_valid && in_ready) begin
            mult_start = 1'b1;
            state_d    = ST_MUL;
          end
        end
        ST_MUL: begin
          if (mult_done) begin
            state_d = ST_ACC;
          end
        end
        ST_ACC: begin
          sig_out_d   = acc_next;
          out_valid_d = 1'b1;
          state_d     = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      sig_out_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sig_out_q   <= sig_out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign sig_out   = sig_out_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_serial_integrator.sv
module tb_serial_integrator;

  logic               clk = 1'b0;
  logic               reset;
  logic               clear;
  logic signed [11:0] ki;
  logic signed [15:0] sig_in;
  logic               in_valid;
  logic               in_ready;
  logic signed [21:0] sig_out;
  logic               out_valid;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  typedef struct {
    logic signed [21:0] val;
    int                 hs;
  } exp_t;

  exp_t sb_q[$];

  serial_integrator dut (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear),
    .ki        (ki),
    .sig_in    (sig_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sig_out   (sig_out),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Monitor: every out_valid pulse is matched against the oldest expectation.
  always @(negedge clk) begin
    if (!reset && out_valid) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_out_valid: got sig_out %0d with no sample pending (cycle %0d)",
                 sig_out, cyc);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("sig_out", longint'(sig_out), longint'(e.val));
        chk("latency", longint'(cyc - e.hs), 13);
        chk("ready_with_valid", longint'(in_ready), 1);
      end
    end
  end

  task automatic send(input logic signed [11:0] k, input logic signed [15:0] x,
                      input bit expect_out, input logic signed [21:0] exp, output int hs);
    int n;
    n = 0;
    @(negedge clk);
    ki       = k;
    sig_in   = x;
    in_valid = 1'b1;
    #1;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!in_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL handshake_timeout: in_ready stayed 0 for %0d cycles", n);
      in_valid = 1'b0;
      hs = -1;
      return;
    end
    @(posedge clk);
    #1;
    hs = cyc;
    if (expect_out) begin
      exp_t e;
      e.val = exp;
      e.hs  = hs;
      sb_q.push_back(e);
    end
    in_valid = 1'b0;
    // Post-acceptance junk on the inputs must not reach the result.
    ki       = 12'sh5A5;
    sig_in   = 16'sh7FFF;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sb_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: %0d results still pending", sb_q.size());
      sb_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    #1;
    chk("sig_out_after_clear", longint'(sig_out), 0);
  endtask

  // Accept a sample whose result must never appear, then clear during the
  // n-th cycle after the handshake edge.
  task automatic clear_in_flight(input int n, input logic signed [15:0] x);
    int hs;
    send(12'sd1024, x, 1'b0, '0, hs);
    repeat (n) @(negedge clk);
    clear = 1'b1;
    #1;
    chk("ready_during_clear", longint'(in_ready), 0);
    @(negedge clk);
    clear = 1'b0;
    #1;
    chk("abort_sig_out", longint'(sig_out), 0);
    chk("abort_out_valid", longint'(out_valid), 0);
    chk("abort_ready_next", longint'(in_ready), 1);
    repeat (16) @(negedge clk);
  endtask

  initial begin
    int hs;
    int prev_hs;
    bit busy_rdy;
    logic signed [21:0] e;

    reset    = 1'b1;
    clear    = 1'b0;
    in_valid = 1'b0;
    ki       = '0;
    sig_in   = '0;

    repeat (3) @(negedge clk);
    chk("reset_in_ready", longint'(in_ready), 0);
    chk("reset_out_valid", longint'(out_valid), 0);
    chk("reset_sig_out", longint'(sig_out), 0);
    reset = 1'b0;
    #1;
    chk("ready_after_reset", longint'(in_ready), 1);

    // Unity gain
    send(12'sd1024, 16'sd100, 1'b1, 22'sd100, hs);
    wait_drain();

    // Floor rounding: -1536 >>> 10 = -2
    do_clear();
    send(12'sd512, -16'sd3, 1'b1, -22'sd2, hs);
    send(12'sd512, -16'sd3, 1'b1, -22'sd4, hs);
    wait_drain();

    // Extreme operands
    do_clear();
    send(-12'sd2048, -16'sd32768, 1'b1, 22'sd65536, hs);
    send(-12'sd2048, 16'sd32767, 1'b1, 22'sd2, hs);
    wait_drain();

    // Clear on the 5th MUL cycle, then a fresh sample
    clear_in_flight(5, 16'sd5);
    send(12'sd1024, 16'sd7, 1'b1, 22'sd7, hs);
    wait_drain();

    // Clear in the ACC cycle wins over the update
    clear_in_flight(13, 16'sd9);

    // Overflow: each sample adds 65502
    for (int k = 1; k <= 33; k++) begin
      if (k <= 32) begin
        e = 22'(k * 65502);
      end else begin
`ifdef SERIAL_INTEGRATOR_CLAMP_EN
        e = 22'sd2097151;
`else
        e = -22'sd2032738;
`endif
      end
      send(12'sd2047, 16'sd32767, 1'b1, e, hs);
    end
`ifdef SERIAL_INTEGRATOR_CLAMP_EN
    send(12'sd2047, -16'sd32768, 1'b1, 22'sd2031647, hs);
`else
    send(12'sd2047, -16'sd32768, 1'b1, 22'sd2096062, hs);
`endif
    wait_drain();

    // Throughput with in_valid held high
    do_clear();
    @(negedge clk);
    ki       = 12'sd1024;
    sig_in   = 16'sd1;
    in_valid = 1'b1;
    prev_hs  = 0;
    for (int i = 0; i < 5; i++) begin
      int n;
      exp_t x;
      n = 0;
      #1;
      while (!in_ready && n < 50) begin
        @(negedge clk);
        #1;
        n++;
      end
      if (!in_ready) begin
        n_cmp++;
        n_bad++;
        $display("FAIL stream_timeout: in_ready stayed 0 for %0d cycles", n);
        break;
      end
      @(posedge clk);
      #1;
      hs    = cyc;
      x.val = 22'(i + 1);
      x.hs  = hs;
      sb_q.push_back(x);
      if (i > 0) chk("accept_interval", longint'(hs - prev_hs), 14);
      prev_hs  = hs;
      busy_rdy = 1'b0;
      for (int j = 1; j <= 13; j++) begin
        @(negedge clk);
        if (j == 5) begin
          ki     = -12'sd2048;
          sig_in = -16'sd32768;
        end
        if (j == 10) begin
          ki     = 12'sd1024;
          sig_in = 16'sd1;
        end
        #1;
        busy_rdy = busy_rdy | in_ready;
      end
      chk("ready_low_while_busy", longint'(busy_rdy), 0);
    end
    in_valid = 1'b0;
    wait_drain();
    repeat (5) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/serial_integrator.md
# serial_integrator

Discrete-time integrator for the fixed-point control path: each accepted sample is scaled by a signed gain `ki` and added to a running accumulator, y[n] = y[n-1] + ((ki·x[n]) >>> FRAC). The multiply is bit-serial to save DSP resources. The AW-bit result feeds the downstream saturation stage, which narrows it to the 16-bit signal width; the default AW matches that stage's 22-bit input.

## Interface
- DW, 16: signed input sample width
- KW, 12: signed gain width (multiply takes KW cycles)
- AW, 22: signed accumulator/output width
- FRAC, 10: fractional bits of `ki`; the product is arithmetic-shifted right by FRAC

- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- clear  in  1  synchronous accumulator clear / operation abort
- ki  in  KW  signed gain, sampled at acceptance
- sig_in  in  DW  signed input sample
- in_valid  in  1  sample present
- in_ready  out  1  block can accept a sample
- sig_out  out  AW  signed accumulator value (registered)
- out_valid  out  1  one-cycle pulse: sig_out has just been updated

## Operation
- FSM states: IDLE, MUL, ACC.
  - IDLE: in_ready = 1 unless clear is high. A handshake occurs when in_valid && in_ready. On a handshake, sig_in and ki are latched, the product register is cleared, the bit counter is set to 0, and the FSM moves to MUL.
  - MUL: lasts exactly KW cycles, processing one ki bit per cycle, LSB first. For bits 0..KW-2, the sign-extended x shifted left by the bit index is added when the bit is 1. For bit KW-1 (the sign bit), it is subtracted instead. This gives an exact signed DW+KW-bit product, including ki = −2^(KW-1) and x = −2^(DW-1). When the count reaches KW-1, the FSM moves to ACC.
  - ACC: computes p = product >>> FRAC (arithmetic shift, rounding toward −∞), sign-extends p to AW+1 bits, and forms sum = sig_out + p. It then registers sig_out, asserts out_valid for one cycle, and returns to IDLE.
- Without the clamp feature, the accumulator wraps in AW-bit two's complement (sig_out = sum[AW-1:0]).
- `ki` and `sig_in` changes after acceptance are ignored.
- `clear` has the highest priority after reset. It sets sig_out to 0, sends the FSM to IDLE, suppresses out_valid, and discards any in-flight product. in_ready is 0 during the clear cycle, so in_valid is not accepted then.
- `reset` has the same effect as `clear`, and additionally clears all internal registers.

## Timing
- Reset values: in_ready = 0 during reset, 1 the cycle after; sig_out = 0; out_valid = 0; FSM in IDLE.
- Cycle numbering: the handshake edge is edge 0. MUL occupies edges 1..KW. ACC is edge KW+1, after which sig_out and out_valid are visible.
- Latency from handshake to out_valid: KW+1 cycles (13 at defaults).
- in_ready is high again in the same cycle that out_valid is high. Back-to-back throughput is one sample per KW+2 cycles.
- A clear asserted in the ACC cycle wins: no out_valid, and sig_out = 0.

## Configuration
- `SERIAL_INTEGRATOR_CLAMP_EN` defined: in ACC, the sum is saturated to [−2^(AW-1), 2^(AW-1)−1], giving anti-windup at the accumulator limits.
- `SERIAL_INTEGRATOR_CLAMP_EN` not defined: the accumulator wraps modulo 2^AW. No extra logic is generated.

## Structure
- Shared package holds:
  - FSM state typedef (IDLE/MUL/ACC)
  - default width constants DW/KW/AW/FRAC
  - the AW-bit MAX/MIN localparam helpers, also used by the saturation stage
- One sub-module: `serial_mult`, the KW-cycle signed shift-add multiplier with start/done.
- The top level contains the FSM, accumulator, clamp and handshake logic.

## Test plan (defaults DW=16, KW=12, AW=22, FRAC=10)
- Unity gain: ki=1024, x=100, single sample from reset → out_valid exactly 13 cycles after the handshake, sig_out=100.
- Floor rounding: ki=512, x=−3 → product −1536, sig_out=−2. A second identical sample → sig_out=−4.
- Extreme operands: ki=−2048, x=−32768 → sig_out=65536. Then ki=−2048, x=32767 → sig_out=65536−65534=2.
- Overflow: 33 samples with ki=2047, x=32767 (each adds 65502).
  - After 32 samples: sig_out=2096064.
  - After 33 samples without the macro: sig_out=−2032738.
  - After 33 samples with `SERIAL_INTEGRATOR_CLAMP_EN`: sig_out=2097151.
  - A 34th sample with x=−32768, ki=2047 in the clamped build → 2097151−65504=2031647.
- Clear mid-operation: accept a sample, assert clear on the 5th MUL cycle → no out_valid, sig_out=0, in_ready=1 on the next cycle. A new sample (ki=1024, x=7) then gives sig_out=7.
- Handshake and throughput: hold in_valid high continuously with ki=1024, x=1 → in_ready is high only in IDLE, exactly one acceptance per 14 cycles, sig_out increments by 1 per out_valid pulse, and the ki/sig_in changes made mid-MUL have no effect.
